// File: rtl/cdb_arb.sv
// Commit-data-bus arbiter: rotating-priority grant of up to CDB_NUM_LANES
// execution results per cycle, with per-lane holding FIFOs for the losers.
module cdb_arb #(
  parameter int CPU_NUM_LANES = 4,
  parameter int CDB_NUM_LANES = 2,
  parameter int ROBID_LEN     = 6,
  parameter int DATA_LEN      = 32,
  parameter int BUF_DEPTH     = 2,
  localparam int LW = (CPU_NUM_LANES > 1) ? $clog2(CPU_NUM_LANES) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               flush_i,
  input  logic [CPU_NUM_LANES-1:0]           ex_v_i,
  input  logic [CPU_NUM_LANES*ROBID_LEN-1:0] ex_robid_i,
  input  logic [CPU_NUM_LANES*DATA_LEN-1:0]  ex_data_i,
  output logic [CPU_NUM_LANES-1:0]           ex_ready_o,
  output logic [CDB_NUM_LANES-1:0]           cdb_v_o,
  output logic [CDB_NUM_LANES*ROBID_LEN-1:0] cdb_robid_o,
  output logic [CDB_NUM_LANES*DATA_LEN-1:0]  cdb_data_o,
  output logic [CDB_NUM_LANES*LW-1:0]        cdb_src_lane_o,
  output logic                               ovf_err_o
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  // Per-lane FIFOs are shift registers: entry 0 is always the head.
  logic [ROBID_LEN-1:0] fifo_robid_q [CPU_NUM_LANES][BUF_DEPTH];
  logic [ROBID_LEN-1:0] fifo_robid_d [CPU_NUM_LANES][BUF_DEPTH];
  logic [DATA_LEN-1:0]  fifo_data_q  [CPU_NUM_LANES][BUF_DEPTH];
  logic [DATA_LEN-1:0]  fifo_data_d  [CPU_NUM_LANES][BUF_DEPTH];
  logic [CW-1:0]        cnt_q        [CPU_NUM_LANES];
  logic [CW-1:0]        cnt_d        [CPU_NUM_LANES];

  logic [LW-1:0]        rr_q, rr_d;
  logic                 ovf_q, ovf_d;

  logic [CDB_NUM_LANES-1:0] cdb_v_q, cdb_v_d;
  logic [ROBID_LEN-1:0] cdb_robid_q [CDB_NUM_LANES];
  logic [ROBID_LEN-1:0] cdb_robid_d [CDB_NUM_LANES];
  logic [DATA_LEN-1:0]  cdb_data_q  [CDB_NUM_LANES];
  logic [DATA_LEN-1:0]  cdb_data_d  [CDB_NUM_LANES];
  logic [LW-1:0]        cdb_src_q   [CDB_NUM_LANES];
  logic [LW-1:0]        cdb_src_d   [CDB_NUM_LANES];

  logic [CPU_NUM_LANES-1:0] ready;
  logic [CPU_NUM_LANES-1:0] busy;
  logic [CPU_NUM_LANES-1:0] cand_v;
  logic [CPU_NUM_LANES-1:0] gnt;
  logic [ROBID_LEN-1:0] in_robid   [CPU_NUM_LANES];
  logic [DATA_LEN-1:0]  in_data    [CPU_NUM_LANES];
  logic [ROBID_LEN-1:0] cand_robid [CPU_NUM_LANES];
  logic [DATA_LEN-1:0]  cand_data  [CPU_NUM_LANES];

  always_comb begin
    for (int i = 0; i < CPU_NUM_LANES; i++) begin
      in_robid[i]   = ex_robid_i[i*ROBID_LEN +: ROBID_LEN];
      in_data[i]    = ex_data_i[i*DATA_LEN +: DATA_LEN];
      ready[i]      = cnt_q[i] < CW'(BUF_DEPTH);
      busy[i]       = cnt_q[i] != '0;
      // A non-empty FIFO always wins over the incoming result to keep lane order.
      cand_v[i]     = busy[i] | ex_v_i[i];
      cand_robid[i] = busy[i] ? fifo_robid_q[i][0] : in_robid[i];
      cand_data[i]  = busy[i] ? fifo_data_q[i][0]  : in_data[i];
    end
  end

  assign ex_ready_o = ready;

  always_comb begin : arb
    int idx;
    int n_gnt;
    int last;
    gnt     = '0;
    cdb_v_d = '0;
    n_gnt   = 0;
    last    = 0;
    idx     = 0;
    for (int l = 0; l < CDB_NUM_LANES; l++) begin
      cdb_robid_d[l] = cdb_robid_q[l];
      cdb_data_d[l]  = cdb_data_q[l];
      cdb_src_d[l]   = cdb_src_q[l];
    end
    for (int k = 0; k < CPU_NUM_LANES; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= CPU_NUM_LANES) idx = idx - CPU_NUM_LANES;
      if (!flush_i && cand_v[idx] && n_gnt < CDB_NUM_LANES) begin
        gnt[idx]           = 1'b1;
        cdb_v_d[n_gnt]     = 1'b1;
        cdb_robid_d[n_gnt] = cand_robid[idx];
        cdb_data_d[n_gnt]  = cand_data[idx];
        cdb_src_d[n_gnt]   = LW'(idx);
        last               = idx;
        n_gnt              = n_gnt + 1;
      end
    end
    if (flush_i)         rr_d = '0;
    else if (n_gnt != 0) rr_d = LW'((last + 1) % CPU_NUM_LANES);
    else                 rr_d = rr_q;
  end

  always_comb begin : fifo_next
    logic pop;
    logic push;
    int   wpos;
    pop   = 1'b0;
    push  = 1'b0;
    wpos  = 0;
    ovf_d = ovf_q | (|(ex_v_i & ~ready));
    for (int i = 0; i < CPU_NUM_LANES; i++) begin
      pop  = gnt[i] & busy[i];
      // Incoming result is stored unless it went straight onto the CDB or overflowed.
      push = ex_v_i[i] & ready[i] & ~(gnt[i] & ~busy[i]);
      for (int j = 0; j < BUF_DEPTH; j++) begin
        fifo_robid_d[i][j] = fifo_robid_q[i][j];
        fifo_data_d[i][j]  = fifo_data_q[i][j];
      end
      if (pop) begin
        for (int j = 0; j < BUF_DEPTH - 1; j++) begin
          fifo_robid_d[i][j] = fifo_robid_q[i][j+1];
          fifo_data_d[i][j]  = fifo_data_q[i][j+1];
        end
      end
      wpos = int'(cnt_q[i]) - (pop ? 1 : 0);
      if (push) begin
        fifo_robid_d[i][wpos] = in_robid[i];
        fifo_data_d[i][wpos]  = in_data[i];
      end
      if (flush_i) cnt_d[i] = '0;
      else         cnt_d[i] = cnt_q[i] + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q    <= '0;
      ovf_q   <= 1'b0;
      cdb_v_q <= '0;
      for (int i = 0; i < CPU_NUM_LANES; i++) cnt_q[i] <= '0;
      for (int l = 0; l < CDB_NUM_LANES; l++) begin
        cdb_robid_q[l] <= '0;
        cdb_data_q[l]  <= '0;
        cdb_src_q[l]   <= '0;
      end
    end else begin
      rr_q    <= rr_d;
      ovf_q   <= ovf_d;
      cdb_v_q <= cdb_v_d;
      for (int i = 0; i < CPU_NUM_LANES; i++) cnt_q[i] <= cnt_d[i];
      for (int l = 0; l < CDB_NUM_LANES; l++) begin
        cdb_robid_q[l] <= cdb_robid_d[l];
        cdb_data_q[l]  <= cdb_data_d[l];
        cdb_src_q[l]   <= cdb_src_d[l];
      end
    end
  end

  // Storage contents are qualified by cnt_q, so they need no reset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < CPU_NUM_LANES; i++) begin
      for (int j = 0; j < BUF_DEPTH; j++) begin
        fifo_robid_q[i][j] <= fifo_robid_d[i][j];
        fifo_data_q[i][j]  <= fifo_data_d[i][j];
      end
    end
  end

  assign cdb_v_o   = cdb_v_q;
  assign ovf_err_o = ovf_q;

  for (genvar l = 0; l < CDB_NUM_LANES; l++) begin : g_pack
    assign cdb_robid_o[l*ROBID_LEN +: ROBID_LEN] = cdb_robid_q[l];
    assign cdb_data_o[l*DATA_LEN +: DATA_LEN]    = cdb_data_q[l];
    assign cdb_src_lane_o[l*LW +: LW]            = cdb_src_q[l];
  end

endmodule
